// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_pkg
// Purpose  : Shared AXI4-Lite response codes, initiator FSM state encoding
//            and the LSTM accelerator register-map constants.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

    // AXI4-Lite response codes carried on bresp/rresp
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Initiator FSM states
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RSP          = 3'd5
    } state_t;

    // LSTM accelerator register map for a four-layer build
    localparam int          LAYERS     = 4;
    localparam logic [31:0] X_IN_ADDR  = 32'h0000_0120;
    localparam logic [31:0] Y_OUT_ADDR = 32'h0000_0124;
    localparam logic [31:0] C_OUT_ADDR = 32'h0000_0128;

endpackage : axi4_lite_pkg
`default_nettype wire

// File: rtl/axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_master
// Purpose  : Single-outstanding AXI4-Lite initiator. Converts a simple
//            command stream into AXI4-Lite write/read transactions and
//            returns each completion on a response stream.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter logic [2:0] PROT = 3'b000,
    parameter logic [3:0] STRB = 4'hF
) (
    input  logic        clk,
    input  logic        rst,

    // command stream
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,

    // response stream
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_resp,

    // AXI4-Lite write address channel
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    // AXI4-Lite write data channel
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,

    // AXI4-Lite write response channel
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,

    // AXI4-Lite read address channel
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    // AXI4-Lite read data channel
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,

    // status
    output logic        busy,
    output logic        err,
    input  logic        err_clear,
    output logic [15:0] txn_count
);

    state_t r_state;

    // Per-channel completion flags for the write address/data phase
    logic r_aw_done;
    logic r_w_done;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_fin;
    logic w_w_fin;
    logic w_err_capture;

    // Protection and strobe are fixed for every transaction
    assign awprot = PROT;
    assign arprot = PROT;
    assign wstrb  = STRB;

    // Status decodes straight from the state register, so they are glitch-free
    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

    assign w_aw_hs  = awvalid & awready;
    assign w_w_hs   = wvalid & wready;
    // A channel is finished if it handshook earlier or is handshaking now
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;

    // Error detection coincides with the bresp/rresp capture cycle
    assign w_err_capture = ((r_state == WR_RESP) && bvalid && (bresp != OKAY)) ||
                           ((r_state == RD_DATA) && rvalid && (rresp != OKAY));

    // Transaction sequencer: all AXI and response outputs are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_data  <= '0;
            rsp_resp  <= '0;
            txn_count <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            awaddr    <= cmd_addr;
                            wdata     <= cmd_data;
                            awvalid   <= 1'b1;
                            wvalid    <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= WR_ADDR_DATA;
                        end else begin
                            araddr    <= cmd_addr;
                            arvalid   <= 1'b1;
                            r_state   <= RD_ADDR;
                        end
                    end
                end

                WR_ADDR_DATA: begin
                    // Each channel retires on its own handshake and then stays low
                    if (w_aw_hs) begin
                        awvalid   <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        wvalid   <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        bready    <= 1'b1;
                        r_state   <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_data  <= '0;
                        rsp_resp  <= bresp;
                        r_state   <= RSP;
                    end
                end

                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_data  <= rdata;
                        rsp_resp  <= rresp;
                        r_state   <= RSP;
                    end
                end

                RSP: begin
                    // Fields are held until the consumer takes the completion
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + 16'd1;
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flag; a new error takes priority over a clear request
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (w_err_capture) begin
            err <= 1'b1;
        end else if (err_clear) begin
            err <= 1'b0;
        end
    end

endmodule : axi4_lite_master
`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_master
// Purpose  : Self-checking bench for axi4_lite_master with a delay-configurable
//            AXI4-Lite slave and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    localparam logic [2:0] c_PROT = 3'b101;
    localparam logic [3:0] c_STRB = 4'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_data;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        busy, err, err_clear;
    logic [15:0] txn_count;

    always #5 clk = ~clk;

    axi4_lite_master #(.PROT(c_PROT), .STRB(c_STRB)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .busy(busy), .err(err), .err_clear(err_clear), .txn_count(txn_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Slave configuration for the current transaction
    int         cfg_awd, cfg_wd, cfg_bd, cfg_ard, cfg_rd;
    logic [1:0] cfg_resp;

    // Slave storage and reference-model storage
    logic [31:0] slv_mem   [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];
    int          m_count;
    bit          m_err;

    // Per-transaction counts of cycles each handshake signal is high
    int n_aw, n_w, n_b, n_ar, n_r, n_rsp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural AXI4-Lite slave; drives on the falling edge
    initial begin : slave
        logic [31:0] s_awaddr, s_wdata, s_araddr;
        bit aw_done, w_done, ar_done, b_seen, r_seen;
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        s_awaddr = 0; s_wdata = 0; s_araddr = 0;
        aw_done = 0; w_done = 0; ar_done = 0; b_seen = 0; r_seen = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rdata = 0; rresp = 0;
                aw_done = 0; w_done = 0; ar_done = 0; b_seen = 0; r_seen = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                continue;
            end
            if (b_seen) begin
                bvalid = 0; bresp = 0; b_seen = 0; aw_done = 0; w_done = 0; b_cnt = 0;
            end
            if (r_seen) begin
                rvalid = 0; rdata = 0; rresp = 0; r_seen = 0; ar_done = 0; r_cnt = 0;
            end
            if (awready) begin
                awready = 0; aw_done = 1; aw_cnt = 0;
            end else if (awvalid && !aw_done) begin
                if (aw_cnt >= cfg_awd) begin awready = 1; s_awaddr = awaddr; end
                else aw_cnt++;
            end
            if (wready) begin
                wready = 0; w_done = 1; w_cnt = 0;
            end else if (wvalid && !w_done) begin
                if (w_cnt >= cfg_wd) begin wready = 1; s_wdata = wdata; end
                else w_cnt++;
            end
            if (aw_done && w_done && !bvalid) begin
                if (b_cnt >= cfg_bd) begin
                    bvalid = 1; bresp = cfg_resp;
                    if (cfg_resp == OKAY) slv_mem[s_awaddr] = s_wdata;
                end else b_cnt++;
            end
            if (bvalid && bready) b_seen = 1;
            if (arready) begin
                arready = 0; ar_done = 1; ar_cnt = 0;
            end else if (arvalid && !ar_done) begin
                if (ar_cnt >= cfg_ard) begin arready = 1; s_araddr = araddr; end
                else ar_cnt++;
            end
            if (ar_done && !rvalid) begin
                if (r_cnt >= cfg_rd) begin
                    rvalid = 1; rresp = cfg_resp;
                    rdata  = slv_mem.exists(s_araddr) ? slv_mem[s_araddr] : 32'h0;
                end else r_cnt++;
            end
            if (rvalid && rready) r_seen = 1;
        end
    end

    // Activity monitor sampling on the falling edge
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (awvalid)   n_aw++;
            if (wvalid)    n_w++;
            if (bready)    n_b++;
            if (arvalid)   n_ar++;
            if (rready)    n_r++;
            if (rsp_valid) n_rsp++;
        end
    end

    // One command through to its completion; entered and left on a falling edge
    task automatic run(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input int awd, input int wd, input int bd, input int ard, input int rd,
                       input logic [1:0] resp, input int hold, input bit clr);
        logic [31:0] exp_data;
        bit          exp_err_rsp;
        int          exp_lat;
        int          t;
        int          c0;
        cfg_awd = awd; cfg_wd = wd; cfg_bd = bd; cfg_ard = ard; cfg_rd = rd; cfg_resp = resp;
        exp_data = wr ? 32'h0 : (model_mem.exists(addr) ? model_mem[addr] : 32'h0);
        if (wr && resp == OKAY) model_mem[addr] = data;
        exp_lat  = wr ? 3 + ((awd > wd) ? awd : wd) + bd : 3 + ard + rd;
        exp_err_rsp = (resp != OKAY) || (!clr && m_err);
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_rsp = 0;
        err_clear = clr;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_data = data;
        t = 0;
        while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        c0 = cyc;
        @(negedge clk);
        cmd_valid = 0; cmd_write = 1'($urandom_range(0, 1));
        cmd_addr = $urandom; cmd_data = $urandom;
        t = 0;
        while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
        chk("latency", 32'(cyc - c0), 32'(exp_lat));
        chk("err_at_rsp", 32'(err), 32'(exp_err_rsp));
        for (int i = 0; i <= hold; i++) begin
            if (i == hold) rsp_ready = 1;
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_write", 32'(rsp_write), 32'(wr));
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_resp", 32'(rsp_resp), 32'(resp));
            chk("cmd_ready_hold", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 0;
        err_clear = 0;
        m_err   = clr ? 1'b0 : exp_err_rsp;
        m_count = (m_count + 1) & 16'hFFFF;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("txn_count", 32'(txn_count), 32'(m_count));
        chk("err", 32'(err), 32'(m_err));
        chk("aw_cycles", 32'(n_aw), wr ? 32'(awd + 1) : 32'd0);
        chk("w_cycles",  32'(n_w),  wr ? 32'(wd + 1)  : 32'd0);
        chk("b_cycles",  32'(n_b),  wr ? 32'(bd + 1)  : 32'd0);
        chk("ar_cycles", 32'(n_ar), wr ? 32'd0 : 32'(ard + 1));
        chk("r_cycles",  32'(n_r),  wr ? 32'd0 : 32'(rd + 1));
        chk("rsp_cycles", 32'(n_rsp), 32'(hold + 1));
    endtask

    // Global time bound
    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded its time bound");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] addr_tbl [4];
        addr_tbl[0] = X_IN_ADDR; addr_tbl[1] = Y_OUT_ADDR;
        addr_tbl[2] = C_OUT_ADDR; addr_tbl[3] = 32'h0000_0010;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_data = 0;
        rsp_ready = 0; err_clear = 0;
        cfg_awd = 0; cfg_wd = 0; cfg_bd = 0; cfg_ard = 0; cfg_rd = 0; cfg_resp = OKAY;
        m_count = 0; m_err = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_awprot", 32'(awprot), 32'(c_PROT));
        chk("rst_arprot", 32'(arprot), 32'(c_PROT));
        chk("rst_wstrb", 32'(wstrb), 32'(c_STRB));
        chk("rst_txn_count", 32'(txn_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 0;
        @(negedge clk);

        // Zero-wait write to the x input register
        run(1, X_IN_ADDR, 32'h0000_1234, 0, 0, 0, 0, 0, OKAY, 0, 0);
        // awready delayed 3 cycles, wready 1 cycle
        run(1, 32'h0000_0000, 32'hDEAD_BEEF, 3, 1, 0, 0, 0, OKAY, 0, 0);
        // Preload then read back with a slow R channel
        run(1, Y_OUT_ADDR, 32'h0000_00AB, 0, 0, 0, 0, 0, OKAY, 0, 0);
        run(0, Y_OUT_ADDR, 32'h0, 0, 0, 0, 0, 5, OKAY, 0, 0);
        // Slave error, then an OKAY transaction keeps the sticky flag
        run(1, C_OUT_ADDR, 32'h0000_0055, 0, 0, 1, 0, 0, SLVERR, 0, 0);
        run(0, X_IN_ADDR, 32'h0, 0, 0, 0, 1, 0, OKAY, 0, 0);
        chk("err_sticky", 32'(err), 32'd1);
        err_clear = 1;
        @(negedge clk);
        err_clear = 0;
        m_err = 0;
        chk("err_cleared", 32'(err), 32'd0);
        // Clear held while a new error arrives: the error wins at capture
        run(0, C_OUT_ADDR, 32'h0, 0, 0, 0, 0, 0, DECERR, 0, 1);
        // Consumer stalls the response for 10 cycles
        run(0, X_IN_ADDR, 32'h0, 1, 0, 0, 2, 0, OKAY, 10, 0);

        // Randomised traffic
        for (int k = 0; k < 40; k++) begin
            int         rsel;
            logic [1:0] rsp_code;
            rsel = $urandom_range(0, 5);
            rsp_code = (rsel == 4) ? SLVERR : (rsel == 5) ? DECERR : OKAY;
            run(1'($urandom_range(0, 1)), addr_tbl[$urandom_range(0, 3)], $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), rsp_code,
                $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
        end

        // Reset while a write address is still pending
        cfg_awd = 6; cfg_wd = 6; cfg_bd = 0; cfg_resp = OKAY;
        cmd_valid = 1; cmd_write = 1; cmd_addr = X_IN_ADDR; cmd_data = 32'h0BAD_0BAD;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        chk("pre_rst_awvalid", 32'(awvalid), 32'd1);
        rst = 1;
        @(posedge clk);
        #1;
        chk("abort_awvalid", 32'(awvalid), 32'd0);
        chk("abort_wvalid", 32'(wvalid), 32'd0);
        chk("abort_arvalid", 32'(arvalid), 32'd0);
        chk("abort_bready", 32'(bready), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_txn_count", 32'(txn_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        m_count = 0; m_err = 0;
        // Recovery: the aborted write must not have landed
        run(0, X_IN_ADDR, 32'h0, 0, 0, 0, 0, 0, OKAY, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_axi4_lite_master
`default_nettype wire
